// File: rtl/signedness_pkg.sv
// Shared types and default widths for the signedness sweep response checker.
package signedness_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int unsigned A_W_DEF       = 3;
  localparam int unsigned B_W_DEF       = 2;
  localparam int unsigned C_W_DEF       = 5;
  localparam int unsigned N_SAMPLES_DEF = 1683;
  localparam int unsigned CNT_W_DEF     = 16;

  localparam logic [1:0] ERR_SIGNED   = 2'b01;
  localparam logic [1:0] ERR_UNSIGNED = 2'b10;

endpackage

// File: rtl/signedness_golden.sv
// Golden adder: signed sum with sign extension, unsigned sum with zero extension.
module signedness_golden #(
  parameter int unsigned A_W = 3,
  parameter int unsigned B_W = 2,
  parameter int unsigned C_W = 5
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  input  logic [A_W-1:0] au_i,
  input  logic [B_W-1:0] bu_i,
  output logic [C_W-1:0] exp_s_o,
  output logic [C_W-1:0] exp_u_o
);

  always_comb begin
    exp_s_o = {{(C_W-A_W){a_i[A_W-1]}}, a_i} + {{(C_W-B_W){b_i[B_W-1]}}, b_i};
    exp_u_o = {{(C_W-A_W){1'b0}}, au_i} + {{(C_W-B_W){1'b0}}, bu_i};
  end

endmodule

// File: rtl/signedness_resp_checker.sv
// Response checker: accepts sweep samples, recomputes golden sums in a 2-stage
// pipeline, counts mismatches and latches the first failing sample.
module signedness_resp_checker
  import signedness_pkg::*;
#(
  parameter int unsigned A_W       = A_W_DEF,
  parameter int unsigned B_W       = B_W_DEF,
  parameter int unsigned C_W       = C_W_DEF,
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [C_W-1:0]   c,
  input  logic [A_W-1:0]   au,
  input  logic [B_W-1:0]   bu,
  input  logic [C_W-1:0]   cu,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_valid,
  output logic [CNT_W-1:0] err_idx,
  output logic [1:0]       err_kind
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_valid_q, err_valid_d;
  logic [CNT_W-1:0] err_idx_q, err_idx_d;
  logic [1:0]       err_kind_q, err_kind_d;

  logic             p1_valid_q, p1_valid_d;
  logic [C_W-1:0]   p1_c_q, p1_c_d, p1_cu_q, p1_cu_d;
  logic [C_W-1:0]   p1_exp_s_q, p1_exp_s_d, p1_exp_u_q, p1_exp_u_d;
  logic [CNT_W-1:0] p1_idx_q, p1_idx_d;

  logic [C_W-1:0]   exp_s, exp_u;
  logic             start_run, xfer, last_xfer;
  logic [1:0]       kind;

  signedness_golden #(.A_W(A_W), .B_W(B_W), .C_W(C_W)) u_golden (
    .a_i     (a),
    .b_i     (b),
    .au_i    (au),
    .bu_i    (bu),
    .exp_s_o (exp_s),
    .exp_u_o (exp_u)
  );

  assign start_run = start && (state_q == IDLE || state_q == DONE);
  assign xfer      = s_valid && (state_q == RUN);
  assign last_xfer = xfer && (sample_cnt_q == CNT_W'(N_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      err_valid_q  <= 1'b0;
      err_idx_q    <= '0;
      err_kind_q   <= '0;
      p1_valid_q   <= 1'b0;
      p1_c_q       <= '0;
      p1_cu_q      <= '0;
      p1_exp_s_q   <= '0;
      p1_exp_u_q   <= '0;
      p1_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_valid_q  <= err_valid_d;
      err_idx_q    <= err_idx_d;
      err_kind_q   <= err_kind_d;
      p1_valid_q   <= p1_valid_d;
      p1_c_q       <= p1_c_d;
      p1_cu_q      <= p1_cu_d;
      p1_exp_s_q   <= p1_exp_s_d;
      p1_exp_u_q   <= p1_exp_u_d;
      p1_idx_q     <= p1_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_xfer) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == RUN);
    busy    = (state_q == RUN) || (state_q == DRAIN);
    done    = (state_q == DONE);
    pass    = (state_q == DONE) && (err_cnt_q == '0);
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_valid  = err_valid_q;
  assign err_idx    = err_idx_q;
  assign err_kind   = err_kind_q;

  assign kind = {p1_cu_q != p1_exp_u_q, p1_c_q != p1_exp_s_q} & {2{p1_valid_q}};

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_valid_d  = err_valid_q;
    err_idx_d    = err_idx_q;
    err_kind_d   = err_kind_q;
    p1_valid_d   = xfer;
    p1_c_d       = p1_c_q;
    p1_cu_d      = p1_cu_q;
    p1_exp_s_d   = p1_exp_s_q;
    p1_exp_u_d   = p1_exp_u_q;
    p1_idx_d     = p1_idx_q;

    if (xfer) begin
      sample_cnt_d = sample_cnt_q + 1'b1;
      p1_c_d       = c;
      p1_cu_d      = cu;
      p1_exp_s_d   = exp_s;
      p1_exp_u_d   = exp_u;
      p1_idx_d     = sample_cnt_q;
    end

    if (kind != 2'b00) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (!err_valid_q) begin
        err_valid_d = 1'b1;
        err_idx_d   = p1_idx_q;
        err_kind_d  = kind;
      end
    end

    // A new sweep starts from an empty pipeline and a clean error record.
    if (start_run) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      err_valid_d  = 1'b0;
      err_idx_d    = '0;
      err_kind_d   = '0;
      p1_valid_d   = 1'b0;
    end
  end

endmodule
